fight_engine: RTL and testbench
===============================

# fight_engine

Per-frame game-state engine directly upstream of the `vga_display` Avalon slave. On each frame tick it samples both players' controller buttons and applies movement with clamping and collision blocking. It then resolves attacks with cooldowns, updates health and game-over status, and streams the six display registers (p1_x, p1_y, p2_x, p2_y, p1_health, p2_health) to `vga_display` as Avalon-MM writes.

## Interface
- X_MIN, 4: lowest legal x (must be ≥3).
- X_MAX, 155: highest legal x.
- Y_MIN, 4: lowest legal y (must be ≥3).
- Y_MAX, 115: highest legal y.
- ATTACK_RANGE, 8: max |dx| for a hit.
- COOLDOWN, 30: frames before an attacker may hit again.
- INIT_HEALTH, 3: starting health.
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse once per frame (start of vertical blank).
- start  in  1  one-cycle pulse; restarts the match, honoured only in GAMEOVER.
- p1_btn, p2_btn  in  5 each  {attack, down, up, right, left}, active-high, synchronous to clk.
- av_address  out  4  display register index.
- av_writedata  out  8  register value.
- av_write  out  1  write strobe.
- av_chipselect  out  1  asserted together with av_write.
- game_over  out  1  high while in GAMEOVER.
- winner  out  2  01 = P1 won, 10 = P2 won, 11 = draw, 00 = match in progress.

## Operation
- State registers, 8-bit unsigned: p1x/p1y = 10/70, p2x/p2y = 80/70, h1/h2 = INIT_HEALTH, cd1/cd2 = 0, prev_atk1/prev_atk2 = 0.
- FSM: IDLE, MOVE, RESOLVE, WRITE, GAMEOVER.
- IDLE: on frame_tick, latch p1_btn/p2_btn, then go to MOVE.
- MOVE, one cycle:
  - Per player, x ±1 for right/left and y ±1 for down/up. If both directions on an axis are pressed, that axis does not move.
  - Clamp x to [X_MIN, X_MAX] and y to [Y_MIN, Y_MAX].
  - If the tentative boxes overlap (|dx| ≤ 6 and |dy| ≤ 6, computed as 9-bit signed absolute differences), both players keep their old positions. Otherwise both commit.
- RESOLVE, one cycle:
  - A player's attack is an edge: latched attack=1 and prev_atk=0, and that player's cd = 0.
  - A hit requires an attack edge with |dx| ≤ ATTACK_RANGE and |dy| ≤ 6, using the committed positions.
  - A hit decrements the opponent's health, saturating at 0, and loads the attacker's cd with COOLDOWN.
  - Simultaneous hits both apply.
  - A non-attacking player's nonzero cd decrements by 1.
  - prev_atk takes the latched attack bit.
- WRITE, 6 cycles: addresses 0..5 carry p1x, p1y, p2x, p2y, h1, h2, with av_write = av_chipselect = 1 on each cycle. Afterwards:
  - Go to GAMEOVER if h1 = 0 or h2 = 0. winner = 10 if only h1 = 0, 01 if only h2 = 0, 11 if both are 0.
  - Otherwise go to IDLE.
- GAMEOVER:
  - On frame_tick, perform WRITE only: no movement or attack, state frozen, return to GAMEOVER.
  - On start, reload all reset values, clear winner and game_over, go to IDLE.
  - If start and frame_tick arrive in the same cycle, start wins.
- frame_tick arriving outside IDLE/GAMEOVER is ignored and not queued.
- start outside GAMEOVER is ignored.

## Timing
- All outputs are registered. After reset:
  - av_write = 0, av_chipselect = 0, av_address = 0, av_writedata = 0.
  - game_over = 0, winner = 00.
  - FSM in IDLE.
- frame_tick in cycle T:
  - MOVE at T+1, RESOLVE at T+2.
  - Write strobes in cycles T+3..T+8, addresses 0,1,2,3,4,5 in order.
  - IDLE or GAMEOVER at T+9. The earliest honoured next tick is at T+9.
- GAMEOVER refresh: writes in T+1..T+6.
- av_write is never asserted outside WRITE. av_chipselect equals av_write every cycle.
- The slave has no waitrequest; one write is issued per cycle unconditionally.
- reset_n low mid-burst: strobes drop asynchronously, and all state returns to reset values.

## Test plan
- Reset, then frame_tick with no buttons -> writes addr0..5 = 10, 70, 80, 70, 3, 3 in cycles T+3..T+8; av_write low at all other times.
- P1 holds left for 10 frames from x = 10 -> p1_x written as 9, 8, 7, 6, 5, 4, 4, 4, 4, 4. Left+right held together -> x unchanged.
- Place p1x = 60 and p2x = 68 (same y), P1 presses right -> blocked, p1_x stays 60. P1 presses attack (dx = 8) -> h2 written as 2. Attack held on the next frame -> no further hit. Re-press within 30 frames -> no hit; re-press after cooldown expires -> h2 = 1.
- Both players attack in the same frame, in range, both at health 1 -> h1 = h2 = 0, game_over = 1, winner = 11. Subsequent ticks rewrite frozen values and buttons have no effect.
- GAMEOVER, start pulse, then tick -> writes 10, 70, 80, 70, 3, 3; winner = 00.
- frame_tick pulsed again at T+4 -> ignored, exactly six writes. reset_n asserted at T+5 -> av_write = 0 immediately, and the next tick writes the reset values.

Source files
------------

// File: rtl/fight_engine.sv
`timescale 1ns/1ps
// fight_engine
//   Per-frame game-state engine for a two-player fighting game. Once per
//   frame tick it samples both controllers, moves the players (clamped to the
//   arena, blocked on body overlap), resolves attacks with per-player
//   cooldowns, updates health and game-over status, and streams the six
//   display registers to the vga_display Avalon-MM slave.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   frame_tick     one-cycle pulse per frame; honoured only in IDLE/GAMEOVER
//   start          one-cycle pulse; restarts the match, honoured only in GAMEOVER
//   p1_btn/p2_btn  {attack, down, up, right, left}, active-high
//   av_address     display register index (0..5)
//   av_writedata   display register value
//   av_write       write strobe
//   av_chipselect  always equal to av_write
//   game_over      high once the match has ended, until start
//   winner         01 P1 won, 10 P2 won, 11 draw, 00 in progress
//   dbg_state      current FSM state (state_t encoding)
//
// Handshake: the display slave has no waitrequest, so this is a strobe-only
// write port. Every cycle with av_write = 1 is one accepted write of
// av_writedata to av_address; there is no back-pressure and no retry.
module fight_engine #(
    parameter int X_MIN        = 4,
    parameter int X_MAX        = 155,
    parameter int Y_MIN        = 4,
    parameter int Y_MAX        = 115,
    parameter int ATTACK_RANGE = 8,
    parameter int COOLDOWN     = 30,
    parameter int INIT_HEALTH  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [4:0] p1_btn,
    input  logic [4:0] p2_btn,
    output logic [3:0] av_address,
    output logic [7:0] av_writedata,
    output logic       av_write,
    output logic       av_chipselect,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MOVE     = 3'd1,
        S_RESOLVE  = 3'd2,
        S_WRITE    = 3'd3,
        S_GAMEOVER = 3'd4
    } state_t;

    localparam logic [7:0] XMIN8   = 8'(X_MIN);
    localparam logic [7:0] XMAX8   = 8'(X_MAX);
    localparam logic [7:0] YMIN8   = 8'(Y_MIN);
    localparam logic [7:0] YMAX8   = 8'(Y_MAX);
    localparam logic [7:0] CD8     = 8'(COOLDOWN);
    localparam logic [7:0] HEALTH8 = 8'(INIT_HEALTH);
    localparam logic [8:0] RANGE9  = 9'(ATTACK_RANGE);
    localparam logic [8:0] BOX9    = 9'd6;
    localparam logic [7:0] P1X0 = 8'd10;
    localparam logic [7:0] P1Y0 = 8'd70;
    localparam logic [7:0] P2X0 = 8'd80;
    localparam logic [7:0] P2Y0 = 8'd70;

    state_t     state, state_n;
    logic [2:0] wcnt;
    logic [4:0] b1, b2;
    logic [7:0] p1x, p1y, p2x, p2y;
    logic [7:0] h1, h2, cd1, cd2;
    logic       prev1, prev2;

    // One axis step: opposing buttons cancel; result clamped to [lo, hi].
    // lo >= 3 so a decrement from lo never wraps.
    function automatic logic [7:0] step_axis(input logic [7:0] v, input logic inc,
                                             input logic dec, input logic [7:0] lo,
                                             input logic [7:0] hi);
        logic [7:0] t;
        t = v;
        if (inc && !dec) t = v + 8'd1;
        else if (dec && !inc) t = v - 8'd1;
        if (t < lo) t = lo;
        if (t > hi) t = hi;
        return t;
    endfunction

    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? 9'(-d) : 9'(d);
    endfunction

    // Tentative positions for the MOVE cycle.
    logic [7:0] tx1, ty1, tx2, ty2;
    logic       overlap;
    // Attack resolution on committed positions.
    logic       in_range, hit1, hit2;
    // Burst sequencing.
    logic       w_start, w_last, go_over;
    logic [2:0] rd_idx;
    logic [7:0] rd_data;

    always_comb begin
        tx1 = step_axis(p1x, b1[1], b1[0], XMIN8, XMAX8);
        ty1 = step_axis(p1y, b1[3], b1[2], YMIN8, YMAX8);
        tx2 = step_axis(p2x, b2[1], b2[0], XMIN8, XMAX8);
        ty2 = step_axis(p2y, b2[3], b2[2], YMIN8, YMAX8);
        overlap = (abs_diff(tx1, tx2) <= BOX9) && (abs_diff(ty1, ty2) <= BOX9);

        in_range = (abs_diff(p1x, p2x) <= RANGE9) && (abs_diff(p1y, p2y) <= BOX9);
        hit1 = b1[4] && !prev1 && (cd1 == 8'd0) && in_range;
        hit2 = b2[4] && !prev2 && (cd2 == 8'd0) && in_range;
    end

    always_comb begin
        // A GAMEOVER refresh starts the burst directly; start has priority.
        w_start = (state == S_RESOLVE) ||
                  ((state == S_GAMEOVER) && frame_tick && !start);
        w_last  = (state == S_WRITE) && (wcnt == 3'd5);
        go_over = (h1 == 8'd0) || (h2 == 8'd0);
        rd_idx  = 3'(wcnt + 3'd1);
        case (rd_idx)
            3'd1:    rd_data = p1y;
            3'd2:    rd_data = p2x;
            3'd3:    rd_data = p2y;
            3'd4:    rd_data = h1;
            3'd5:    rd_data = h2;
            default: rd_data = p1x;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (frame_tick) state_n = S_MOVE;
            S_MOVE:     state_n = S_RESOLVE;
            S_RESOLVE:  state_n = S_WRITE;
            S_WRITE:    if (w_last) state_n = go_over ? S_GAMEOVER : S_IDLE;
            S_GAMEOVER: begin
                if (start)           state_n = S_IDLE;
                else if (frame_tick) state_n = S_WRITE;
            end
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt          <= 3'd0;
            b1            <= 5'd0;
            b2            <= 5'd0;
            p1x           <= P1X0;
            p1y           <= P1Y0;
            p2x           <= P2X0;
            p2y           <= P2Y0;
            h1            <= HEALTH8;
            h2            <= HEALTH8;
            cd1           <= 8'd0;
            cd2           <= 8'd0;
            prev1         <= 1'b0;
            prev2         <= 1'b0;
            av_address    <= 4'd0;
            av_writedata  <= 8'd0;
            av_write      <= 1'b0;
            av_chipselect <= 1'b0;
            game_over     <= 1'b0;
            winner        <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        b1 <= p1_btn;
                        b2 <= p2_btn;
                    end
                end
                S_MOVE: begin
                    // Overlapping tentative boxes freeze both players.
                    if (!overlap) begin
                        p1x <= tx1;
                        p1y <= ty1;
                        p2x <= tx2;
                        p2y <= ty2;
                    end
                end
                S_RESOLVE: begin
                    if (hit1 && (h2 != 8'd0)) h2 <= h2 - 8'd1;
                    if (hit2 && (h1 != 8'd0)) h1 <= h1 - 8'd1;
                    // Cooldown reloads on a landed hit, otherwise runs down.
                    if (hit1)              cd1 <= CD8;
                    else if (cd1 != 8'd0)  cd1 <= cd1 - 8'd1;
                    if (hit2)              cd2 <= CD8;
                    else if (cd2 != 8'd0)  cd2 <= cd2 - 8'd1;
                    prev1 <= b1[4];
                    prev2 <= b2[4];
                end
                S_WRITE: begin
                    if (w_last && go_over) begin
                        game_over <= 1'b1;
                        winner    <= {h1 == 8'd0, h2 == 8'd0};
                    end
                end
                S_GAMEOVER: begin
                    if (start) begin
                        b1        <= 5'd0;
                        b2        <= 5'd0;
                        p1x       <= P1X0;
                        p1y       <= P1Y0;
                        p2x       <= P2X0;
                        p2y       <= P2Y0;
                        h1        <= HEALTH8;
                        h2        <= HEALTH8;
                        cd1       <= 8'd0;
                        cd2       <= 8'd0;
                        prev1     <= 1'b0;
                        prev2     <= 1'b0;
                        game_over <= 1'b0;
                        winner    <= 2'b00;
                    end
                end
                default: ;
            endcase

            // Registered write port: the word for cycle k is loaded on the
            // edge that ends cycle k-1.
            if (w_start) begin
                wcnt          <= 3'd0;
                av_address    <= 4'd0;
                av_writedata  <= p1x;
                av_write      <= 1'b1;
                av_chipselect <= 1'b1;
            end else if ((state == S_WRITE) && !w_last) begin
                wcnt          <= rd_idx;
                av_address    <= {1'b0, rd_idx};
                av_writedata  <= rd_data;
            end else if (w_last) begin
                av_write      <= 1'b0;
                av_chipselect <= 1'b0;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_fight_engine.sv
`timescale 1ns/1ps
module tb_fight_engine;

  logic       clk;
  logic       reset_n;
  logic       frame_tick;
  logic       start;
  logic [4:0] p1_btn;
  logic [4:0] p2_btn;
  logic [3:0] av_address;
  logic [7:0] av_writedata;
  logic       av_write;
  logic       av_chipselect;
  logic       game_over;
  logic [1:0] winner;
  logic [2:0] dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] wd [6];

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_L    = 5'b00001;
  localparam logic [4:0] B_R    = 5'b00010;
  localparam logic [4:0] B_ATK  = 5'b10000;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OVER = 3'd4;

  fight_engine dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_tick    (frame_tick),
    .start         (start),
    .p1_btn        (p1_btn),
    .p2_btn        (p2_btn),
    .av_address    (av_address),
    .av_writedata  (av_writedata),
    .av_write      (av_write),
    .av_chipselect (av_chipselect),
    .game_over     (game_over),
    .winner        (winner),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input logic [7:0] e4, input logic [7:0] e5);
    check({tag, ".p1_x"}, wd[0], e0);
    check({tag, ".p1_y"}, wd[1], e1);
    check({tag, ".p2_x"}, wd[2], e2);
    check({tag, ".p2_y"}, wd[3], e3);
    check({tag, ".h1"},   wd[4], e4);
    check({tag, ".h2"},   wd[5], e5);
  endtask

  // ---------------- driver ----------------
  // Tick in cycle T; writes expected in T+lead+1 .. T+lead+6, strobe low on
  // every other sampled cycle up to T+lead+9. extra_at != 0 pulses a second
  // frame_tick in cycle T+extra_at.
  task automatic run_frame(input logic [4:0] b1, input logic [4:0] b2,
                           input int lead, input int extra_at);
    @(negedge clk);
    p1_btn     = b1;
    p2_btn     = b2;
    frame_tick = 1'b1;
    for (int c = 1; c <= lead + 9; c++) begin
      @(negedge clk);
      frame_tick = (c == extra_at);
      p1_btn     = B_NONE;
      p2_btn     = B_NONE;
      if (c > lead && c <= lead + 6) begin
        check("wr_strobe", {av_write, av_chipselect, av_address},
              {2'b11, 4'(c - lead - 1)});
        wd[c - lead - 1] = av_writedata;
      end else begin
        check("no_strobe", {av_write, av_chipselect}, 2'b00);
      end
    end
    frame_tick = 1'b0;
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) run_frame(B_NONE, B_NONE, 2, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    p1_btn     = B_NONE;
    p2_btn     = B_NONE;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_av_write", av_write, 1'b0);
    check("rst_av_cs", av_chipselect, 1'b0);
    check("rst_av_addr", av_address, 4'd0);
    check("rst_av_data", av_writedata, 8'd0);
    check("rst_game_over", game_over, 1'b0);
    check("rst_winner", winner, 2'b00);
    check("rst_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;

    // First frame, no buttons
    run_frame(B_NONE, B_NONE, 2, 0);
    check_regs("first", 8'd10, 8'd70, 8'd80, 8'd70, 8'd3, 8'd3);

    // P1 holds left: 9..4 then clamped at X_MIN
    for (int i = 0; i < 10; i++) begin
      run_frame(B_L, B_NONE, 2, 0);
      check("left_walk.p1_x", wd[0], (i < 6) ? 8'(9 - i) : 8'd4);
    end
    run_frame(B_L | B_R, B_NONE, 2, 0);
    check("left_right.p1_x", wd[0], 8'd4);

    // Walk together: p1 4->16, p2 80->68; then p1 on to 60
    for (int i = 0; i < 12; i++) run_frame(B_R, B_L, 2, 0);
    check("approach.p1_x", wd[0], 8'd16);
    check("approach.p2_x", wd[2], 8'd68);
    for (int i = 0; i < 44; i++) run_frame(B_R, B_NONE, 2, 0);
    check_regs("placed", 8'd60, 8'd70, 8'd68, 8'd70, 8'd3, 8'd3);

    // Tentative 61/67 (dx 6) overlap: both frozen
    run_frame(B_R, B_L, 2, 0);
    check_regs("blocked", 8'd60, 8'd70, 8'd68, 8'd70, 8'd3, 8'd3);

    // P1 attack at dx 8 lands
    run_frame(B_ATK, B_NONE, 2, 0);
    check("hit1.h2", wd[5], 8'd2);
    run_frame(B_ATK, B_NONE, 2, 0);
    check("held.h2", wd[5], 8'd2);
    idle_frames(3);
    run_frame(B_ATK, B_NONE, 2, 0);
    check("cooldown.h2", wd[5], 8'd2);
    idle_frames(40);
    run_frame(B_ATK, B_NONE, 2, 0);
    check("rehit.h2", wd[5], 8'd1);
    check("rehit.h1", wd[4], 8'd3);

    // P2 lands two hits, separated by its cooldown
    run_frame(B_NONE, B_ATK, 2, 0);
    check("p2hit.h1", wd[4], 8'd2);
    idle_frames(35);
    run_frame(B_NONE, B_ATK, 2, 0);
    check("p2hit2.h1", wd[4], 8'd1);
    idle_frames(35);

    // Simultaneous hits at health 1: draw
    run_frame(B_ATK, B_ATK, 2, 0);
    check_regs("draw", 8'd60, 8'd70, 8'd68, 8'd70, 8'd0, 8'd0);
    check("draw.game_over", game_over, 1'b1);
    check("draw.winner", winner, 2'b11);
    check("draw.state", dbg_state, ST_OVER);

    // Frozen refresh: writes in T+1..T+6, buttons ignored
    run_frame(B_R, B_ATK, 0, 0);
    check_regs("frozen", 8'd60, 8'd70, 8'd68, 8'd70, 8'd0, 8'd0);
    check("frozen.game_over", game_over, 1'b1);
    check("frozen.winner", winner, 2'b11);
    check("frozen.state", dbg_state, ST_OVER);

    // start and frame_tick together: start wins, no burst
    @(negedge clk);
    start      = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    frame_tick = 1'b0;
    check("restart.state", dbg_state, ST_IDLE);
    check("restart.game_over", game_over, 1'b0);
    check("restart.winner", winner, 2'b00);
    for (int i = 0; i < 3; i++) begin
      check("restart.no_strobe", av_write, 1'b0);
      @(negedge clk);
    end
    run_frame(B_NONE, B_NONE, 2, 0);
    check_regs("restarted", 8'd10, 8'd70, 8'd80, 8'd70, 8'd3, 8'd3);
    check("restarted.winner", winner, 2'b00);

    // Tick at T+4 ignored: six writes only, back in IDLE
    run_frame(B_NONE, B_NONE, 2, 4);
    check("extra_tick.state", dbg_state, ST_IDLE);

    // Move, then reset mid-burst
    run_frame(B_R, B_NONE, 2, 0);
    check("pre_reset.p1_x", wd[0], 8'd11);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    check("midburst.strobe", {av_write, av_chipselect, av_address}, {2'b11, 4'd2});
    reset_n = 1'b0;
    #1;
    check("async_rst.av_write", av_write, 1'b0);
    check("async_rst.av_cs", av_chipselect, 1'b0);
    check("async_rst.av_addr", av_address, 4'd0);
    check("async_rst.state", dbg_state, ST_IDLE);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(B_NONE, B_NONE, 2, 0);
    check_regs("post_reset", 8'd10, 8'd70, 8'd80, 8'd70, 8'd3, 8'd3);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
